wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Parametrised N-master to 1-slave Wishbone arbiter for the bexkat1 core.
- Lets ifetch, mem and future masters (DMA, debug) share one single-port memory or bus segment, replacing the fixed two-port memory arrangement.
- Grant policy is round-robin or fixed priority; grant is held for a whole bus cycle (cyc-locked).
- Optional bus-timeout watchdog returns an error to a stalled master.

Parameters:
- NMASTERS, 2, number of masters; valid range 2..8; index 0 has highest fixed priority.
- AWIDTH, 32, address width.
- DWIDTH, 32, data width; must be a multiple of 8; SWIDTH = DWIDTH/8.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority.
- TIMEOUT, 0, number of stb-without-ack cycles before an error is returned; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- m_cyc_i  in  NMASTERS  per-master bus cycle request.
- m_stb_i  in  NMASTERS  per-master strobe.
- m_we_i  in  NMASTERS  per-master write enable.
- m_sel_i  in  NMASTERS*SWIDTH  byte selects; master k occupies slice [k*SWIDTH +: SWIDTH].
- m_adr_i  in  NMASTERS*AWIDTH  addresses; sliced the same way.
- m_dat_i  in  NMASTERS*DWIDTH  write data; sliced the same way.
- m_dat_o  out  DWIDTH  read data, broadcast to all masters.
- m_ack_o  out  NMASTERS  per-master ack.
- m_err_o  out  NMASTERS  per-master error.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side control.
- s_sel_o  out  SWIDTH  slave-side byte selects.
- s_adr_o  out  AWIDTH  slave-side address.
- s_dat_o  out  DWIDTH  slave-side write data.
- s_dat_i  in  DWIDTH  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave error.
- grant_o  out  NMASTERS  one-hot registered grant; all zero when the bus is idle.
- busy_o  out  1  OR of grant_o.

Behaviour:
- Reset (rst_i low, asynchronous):
  - grant_o = 0; busy_o = 0.
  - last-winner pointer = NMASTERS-1, so master 0 wins the first round-robin arbitration.
  - Timeout counter = 0.
  - All slave outputs 0; m_ack_o = 0; m_err_o = 0.
- States:
  - IDLE (grant_o == 0).
  - OWNED (exactly one grant bit set).
  - RELEASE (one-cycle forced gap after a timeout).
- IDLE:
  - Each cycle, evaluate m_cyc_i. If any bit is set, register a winner: grant_o = one-hot winner, go to OWNED.
  - Arbitration latency is 1 cycle from cyc assertion to grant.
  - Round-robin: search indices last+1, last+2, ... modulo NMASTERS; the first one with cyc set wins; last is updated to the winner.
  - Fixed priority: lowest index with cyc set wins.
- OWNED, owner k:
  - s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o are combinational copies of master k's signals.
  - m_ack_o[k] = s_ack_i and m_err_o[k] = s_err_i, combinationally; non-owners see ack/err = 0.
  - m_dat_o = s_dat_i at all times.
- Releasing the grant:
  - When m_cyc_i[k] is low at a clock edge, re-arbitrate that same edge. Any requester, including k, may win.
  - This allows back-to-back ownership with no idle bubble; if no requester, go to IDLE.
  - The owner keeps the grant across multiple stb/ack beats while cyc stays high (locked cycle).
- Ungranted state: slave outputs are driven all-zero whenever no grant is held or in RELEASE.
- Watchdog (TIMEOUT > 0):
  - Counter increments each OWNED cycle with s_stb_o high and s_ack_i and s_err_i both low.
  - Counter clears on ack, err, stb low, or grant change.
  - When the counter reaches TIMEOUT:
    - Assert m_err_o[k] for exactly one cycle (registered).
    - Clear grant_o and enter RELEASE for one cycle with s_cyc_o = 0.
    - Then go to IDLE arbitration.
  - A late s_ack_i arriving during RELEASE or IDLE is dropped.
- Simultaneous events:
  - s_ack_i and timeout expiry in the same cycle: ack wins and the counter clears.
  - s_ack_i and s_err_i both high: both are forwarded; the master resolves.
  - Owner drops cyc in the same cycle as ack: the ack is still forwarded that cycle.
- Reset mid-transfer: all grants drop immediately (asynchronous); slave cyc falls without a handshake.

Test Plan:
- Reset then m_cyc_i=2'b01 -> grant_o=01 one cycle later; s_adr_o follows master 0; 3 stb/ack beats all routed to m_ack_o[0] only; cyc drop -> grant_o=00 next cycle.
- RR_MODE=1, NMASTERS=4, all cyc held high, each master runs a single beat and then drops cyc -> grant order 0,1,2,3,0 with no idle cycles between owners.
- RR_MODE=0, masters 1 and 2 hold cyc and master 0 requests mid-cycle of master 2 -> master 2 keeps the grant until its cyc drops, then master 0 wins, then master 1; master 3 is never starved while idle.
- TIMEOUT=8, owner strobes and the slave never acks -> m_err_o[owner] pulses 1 cycle after 8 unacked cycles, s_cyc_o low for 1 cycle, next requester granted.
- Slave ack arrives on exactly the 8th cycle with TIMEOUT=8 -> normal ack, no err, grant retained.
- Assert rst_i low during a locked read -> grant_o, s_cyc_o, m_ack_o go to 0 without waiting for clk; after release master 0 is granted first.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: N-master to 1-slave Wishbone arbiter with cyc-locked grants,
// round-robin or fixed-priority selection and an optional stall watchdog.
module wb_bus_arbiter #(
  parameter int NMASTERS = 2,
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int RR_MODE  = 1,
  parameter int TIMEOUT  = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NMASTERS-1:0]              m_cyc_i,
  input  logic [NMASTERS-1:0]              m_stb_i,
  input  logic [NMASTERS-1:0]              m_we_i,
  input  logic [NMASTERS*(DWIDTH/8)-1:0]   m_sel_i,
  input  logic [NMASTERS*AWIDTH-1:0]       m_adr_i,
  input  logic [NMASTERS*DWIDTH-1:0]       m_dat_i,
  output logic [DWIDTH-1:0]                m_dat_o,
  output logic [NMASTERS-1:0]              m_ack_o,
  output logic [NMASTERS-1:0]              m_err_o,
  output logic                             s_cyc_o,
  output logic                             s_stb_o,
  output logic                             s_we_o,
  output logic [(DWIDTH/8)-1:0]            s_sel_o,
  output logic [AWIDTH-1:0]                s_adr_o,
  output logic [DWIDTH-1:0]                s_dat_o,
  input  logic [DWIDTH-1:0]                s_dat_i,
  input  logic                             s_ack_i,
  input  logic                             s_err_i,
  output logic [NMASTERS-1:0]              grant_o,
  output logic                             busy_o
);

  localparam int SWIDTH = DWIDTH / 8;
  localparam int IW     = $clog2(NMASTERS);
  localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [NMASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]       last_q,  last_d;
  logic [CW-1:0]       cnt_q,   cnt_d;
  logic [NMASTERS-1:0] err_q,   err_d;

  logic                win_found;
  logic [IW-1:0]       win_idx;
  logic [IW-1:0]       cand;
  logic [IW-1:0]       own_idx;
  logic                stall;
  logic                expire;

  // Winner search: round-robin starts just after the last winner, fixed priority at index 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NMASTERS; off++) begin
      if (RR_MODE != 0) begin
        cand = IW'((32'(last_q) + off + 1) % NMASTERS);
      end else begin
        cand = IW'(off);
      end
      if (!win_found && m_cyc_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Encode the one-hot grant into the owner index used by the slave mux.
  always_comb begin
    own_idx = '0;
    for (int unsigned i = 0; i < NMASTERS; i++) begin
      if (grant_q[i]) begin
        own_idx = IW'(i);
      end
    end
  end

  // A stalled beat is an owned strobe that the slave neither acks nor errors; an ack on
  // the last allowed cycle therefore never expires.
  assign stall  = (state_q == ST_OWNED) && s_stb_o && !s_ack_i && !s_err_i;
  assign expire = (TIMEOUT != 0) && stall && (int'(cnt_q) == TIMEOUT - 1);

  // Next-state: arbitrate when idle/released or when the owner drops cyc; watchdog expiry
  // forces a one-cycle release with a registered error to the stalled owner.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = '0;
    err_d   = '0;
    case (state_q)
      ST_IDLE, ST_RELEASE: begin
        grant_d = '0;
        state_d = ST_IDLE;
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
          last_d           = win_idx;
          state_d          = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (!m_cyc_i[own_idx]) begin
          grant_d = '0;
          state_d = ST_IDLE;
          if (win_found) begin
            grant_d[win_idx] = 1'b1;
            last_d           = win_idx;
            state_d          = ST_OWNED;
          end
        end else if (expire) begin
          err_d   = grant_q;
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (stall && (TIMEOUT != 0)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset parks the round-robin pointer so master 0 wins first.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NMASTERS - 1);
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Slave-side mux and per-master response routing; everything is zero without an owner.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (state_q == ST_OWNED) begin
      s_cyc_o = m_cyc_i[own_idx];
      s_stb_o = m_stb_i[own_idx];
      s_we_o  = m_we_i[own_idx];
      s_sel_o = m_sel_i[32'(own_idx) * SWIDTH +: SWIDTH];
      s_adr_o = m_adr_i[32'(own_idx) * AWIDTH +: AWIDTH];
      s_dat_o = m_dat_i[32'(own_idx) * DWIDTH +: DWIDTH];
    end
    m_ack_o = grant_q & {NMASTERS{s_ack_i}};
    m_err_o = (grant_q & {NMASTERS{s_err_i}}) | err_q;
  end

  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;
  assign busy_o  = |grant_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: a round-robin instance with an 8-cycle watchdog and a
// fixed-priority instance without one share the same stimulus.
module tb_wb_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*SW-1:0] m_sel;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [DW-1:0]   s_dat;
  logic            s_ack, s_err;

  logic [DW-1:0] dat_r, dat_f, sdat_r, sdat_f;
  logic [AW-1:0] sadr_r, sadr_f;
  logic [N-1:0]  ack_r, ack_f, err_r, err_f, grant_r, grant_f;
  logic [SW-1:0] ssel_r, ssel_f;
  logic          scyc_r, scyc_f, sstb_r, sstb_f, swe_r, swe_f, busy_r, busy_f;

  wb_bus_arbiter #(.NMASTERS(N), .AWIDTH(AW), .DWIDTH(DW), .RR_MODE(1), .TIMEOUT(8)) dut_rr (
    .clk_i(clk), .rst_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(dat_r), .m_ack_o(ack_r), .m_err_o(err_r),
    .s_cyc_o(scyc_r), .s_stb_o(sstb_r), .s_we_o(swe_r), .s_sel_o(ssel_r), .s_adr_o(sadr_r), .s_dat_o(sdat_r),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant_r), .busy_o(busy_r)
  );

  wb_bus_arbiter #(.NMASTERS(N), .AWIDTH(AW), .DWIDTH(DW), .RR_MODE(0), .TIMEOUT(0)) dut_fp (
    .clk_i(clk), .rst_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(dat_f), .m_ack_o(ack_f), .m_err_o(err_f),
    .s_cyc_o(scyc_f), .s_stb_o(sstb_f), .s_we_o(swe_f), .s_sel_o(ssel_f), .s_adr_o(sadr_f), .s_dat_o(sdat_f),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant_f), .busy_o(busy_f)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner index (-1 = nobody), last winner, stall count, pending error target.
  int own[2], last[2], cnt[2], errp[2];
  int rr_of[2]  = '{1, 0};
  int tmo_of[2] = '{8, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; last[d] = N - 1; cnt[d] = 0; errp[d] = -1;
    end
  endtask

  function automatic int pick(input int d);
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (rr_of[d] != 0) ? (last[d] + off) % N : off - 1;
      if (m_cyc[idx]) return idx;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs that were present before it.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int e;
      e = -1;
      if (own[d] < 0 || !m_cyc[own[d]]) begin
        own[d] = pick(d);
        if (own[d] >= 0) last[d] = own[d];
        cnt[d] = 0;
      end else if (tmo_of[d] > 0 && m_stb[own[d]] && !s_ack && !s_err) begin
        cnt[d]++;
        if (cnt[d] == tmo_of[d]) begin
          e = own[d]; own[d] = -1; cnt[d] = 0;
        end
      end else begin
        cnt[d] = 0;
      end
      errp[d] = e;
    end
  endtask

  task automatic check_one(input int d, input string tag, input logic [31:0] dat_o,
                           input logic [3:0] ack, input logic [3:0] err,
                           input logic scyc, input logic sstb, input logic swe,
                           input logic [3:0] ssel, input logic [31:0] sadr, input logic [31:0] sdat,
                           input logic [3:0] grant, input logic busy);
    int o;
    logic [3:0] g, e_ack, e_err, e_sel;
    logic e_cyc, e_stb, e_we;
    logic [31:0] e_adr, e_dat;
    o = own[d];
    g = '0; e_ack = '0; e_err = '0; e_sel = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0;
    if (o >= 0) begin
      g[o]  = 1'b1;
      e_cyc = m_cyc[o]; e_stb = m_stb[o]; e_we = m_we[o];
      e_sel = m_sel[o*SW +: SW]; e_adr = m_adr[o*AW +: AW]; e_dat = m_dat[o*DW +: DW];
      if (s_ack) e_ack = g;
      if (s_err) e_err = g;
    end
    if (errp[d] >= 0) e_err[errp[d]] = 1'b1;
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".busy"},  busy,  o >= 0);
    chk({tag, ".m_ack"}, ack,   e_ack);
    chk({tag, ".m_err"}, err,   e_err);
    chk({tag, ".s_cyc"}, scyc,  e_cyc);
    chk({tag, ".s_stb"}, sstb,  e_stb);
    chk({tag, ".s_we"},  swe,   e_we);
    chk({tag, ".s_sel"}, ssel,  e_sel);
    chk({tag, ".s_adr"}, sadr,  e_adr);
    chk({tag, ".s_dat"}, sdat,  e_dat);
    chk({tag, ".m_dat"}, dat_o, s_dat);
  endtask

  task automatic check_all();
    check_one(0, "rr", dat_r, ack_r, err_r, scyc_r, sstb_r, swe_r, ssel_r, sadr_r, sdat_r, grant_r, busy_r);
    check_one(1, "fp", dat_f, ack_f, err_f, scyc_f, sstb_f, swe_f, ssel_f, sadr_f, sdat_f, grant_f, busy_f);
  endtask

  // Called at negedge+1 with inputs applied: check, clock, advance model, return at negedge.
  task automatic step();
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '1; m_dat = '0;
    s_dat = 32'h5A5A_0000; s_ack = 1'b0; s_err = 1'b0;
    for (int k = 0; k < N; k++) m_adr[k*AW +: AW] = 32'hA000_0000 + 32'(k);
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0] cyc;
    logic       ack;
    logic [3:0] g_rr;
    logic [3:0] g_fp;
    logic [3:0] ack_rr;
  } vec_t;

  vec_t        tbl [27];
  logic [31:0] exp_adr;

  initial begin
    // {cyc (stb mirrors it), s_ack, grant rr, grant fp, m_ack rr} seen during each cycle
    tbl[0]  = {4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = {4'b1111, 1'b1, 4'b0001, 4'b0001, 4'b0001};
    tbl[2]  = {4'b1110, 1'b0, 4'b0001, 4'b0001, 4'b0000};
    tbl[3]  = {4'b1111, 1'b1, 4'b0010, 4'b0010, 4'b0010};
    tbl[4]  = {4'b1101, 1'b0, 4'b0010, 4'b0010, 4'b0000};
    tbl[5]  = {4'b1111, 1'b1, 4'b0100, 4'b0001, 4'b0100};
    tbl[6]  = {4'b1011, 1'b0, 4'b0100, 4'b0001, 4'b0000};
    tbl[7]  = {4'b1111, 1'b1, 4'b1000, 4'b0001, 4'b1000};
    tbl[8]  = {4'b0111, 1'b0, 4'b1000, 4'b0001, 4'b0000};
    tbl[9]  = {4'b1111, 1'b0, 4'b0001, 4'b0001, 4'b0000};
    tbl[10] = {4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000};
    tbl[11] = {4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[12] = {4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[13] = {4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0001};
    tbl[14] = {4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0001};
    tbl[15] = {4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0001};
    tbl[16] = {4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000};
    tbl[17] = {4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[18] = {4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[19] = {4'b0110, 1'b0, 4'b0100, 4'b0100, 4'b0000};
    tbl[20] = {4'b0111, 1'b0, 4'b0100, 4'b0100, 4'b0000};
    tbl[21] = {4'b0011, 1'b0, 4'b0100, 4'b0100, 4'b0000};
    tbl[22] = {4'b0011, 1'b0, 4'b0001, 4'b0001, 4'b0000};
    tbl[23] = {4'b0010, 1'b0, 4'b0001, 4'b0001, 4'b0000};
    tbl[24] = {4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b0000};
    tbl[25] = {4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b0000};
    tbl[26] = {4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};

    // Reset state
    set_idle();
    model_reset();
    s_ack = 1'b1;
    #1;
    chk("reset.grant_rr", grant_r, 4'b0000);
    chk("reset.busy_rr",  busy_r,  1'b0);
    chk("reset.s_cyc_rr", scyc_r,  1'b0);
    chk("reset.m_ack_rr", ack_r,   4'b0000);
    chk("reset.m_err_rr", err_r,   4'b0000);
    do_reset();

    // Directed table: rr rotation, 3-beat locked cycle, fixed-priority hold/preempt order
    for (int i = 0; i < 27; i++) begin
      m_cyc = tbl[i].cyc; m_stb = tbl[i].cyc; s_ack = tbl[i].ack;
      #1;
      chk("tbl.grant_rr", grant_r, tbl[i].g_rr);
      chk("tbl.grant_fp", grant_f, tbl[i].g_fp);
      chk("tbl.m_ack_rr", ack_r,   tbl[i].ack_rr);
      exp_adr = '0;
      for (int k = 0; k < N; k++) if (tbl[i].g_rr[k]) exp_adr = 32'hA000_0000 + 32'(k);
      chk("tbl.s_adr_rr", sadr_r, exp_adr);
      step();
    end

    // Watchdog expiry: master 1 stalls, master 2 waits
    do_reset();
    m_cyc = 4'b0110; m_stb = 4'b0110;
    #1; step();
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk("tmo.grant_hold", grant_r, 4'b0010);
      chk("tmo.no_err",     err_r,   4'b0000);
      step();
    end
    s_ack = 1'b1;
    #1;
    chk("tmo.release_grant", grant_r, 4'b0000);
    chk("tmo.err_pulse",     err_r,   4'b0010);
    chk("tmo.release_scyc",  scyc_r,  1'b0);
    chk("tmo.late_ack_drop", ack_r,   4'b0000);
    step();
    s_ack = 1'b0;
    #1;
    chk("tmo.next_grant", grant_r, 4'b0100);
    chk("tmo.err_gone",   err_r,   4'b0000);
    step();
    set_idle(); #1; step(); #1; step();

    // Ack on the 8th stalled-count cycle is a normal completion
    do_reset();
    m_cyc = 4'b0010; m_stb = 4'b0010;
    #1; step();
    for (int c = 1; c <= 7; c++) begin #1; step(); end
    s_ack = 1'b1;
    #1;
    chk("ack8.m_ack", ack_r, 4'b0010);
    chk("ack8.no_err", err_r, 4'b0000);
    step();
    s_ack = 1'b0;
    #1;
    chk("ack8.grant_kept", grant_r, 4'b0010);
    chk("ack8.err_after",  err_r,   4'b0000);
    step();
    set_idle(); #1; step();

    // Asynchronous reset in the middle of a locked read
    do_reset();
    m_cyc = 4'b0001; m_stb = 4'b0001;
    #1; step();
    s_ack = 1'b1;
    #1;
    chk("arst.pre_ack", ack_r, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.grant_rr", grant_r, 4'b0000);
    chk("arst.grant_fp", grant_f, 4'b0000);
    chk("arst.s_cyc_rr", scyc_r,  1'b0);
    chk("arst.m_ack_rr", ack_r,   4'b0000);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cyc = 4'b0011; m_stb = 4'b0011; s_ack = 1'b0;
    #1; step();
    #1;
    chk("arst.first_rr", grant_r, 4'b0001);
    chk("arst.first_fp", grant_f, 4'b0001);
    step();

    // Randomised traffic against the model, alternating responsive and sluggish slave phases
    set_idle();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if (m_cyc[k]) begin
          if ($urandom_range(0, 9) == 0) m_cyc[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          m_cyc[k] = 1'b1;
        end
        m_stb[k] = m_cyc[k] & ($urandom_range(0, 3) != 0);
        m_we[k]  = 1'($urandom_range(0, 1));
      end
      m_sel = 16'($urandom);
      m_adr = {$urandom, $urandom, $urandom, $urandom};
      m_dat = {$urandom, $urandom, $urandom, $urandom};
      s_dat = $urandom;
      if (((i / 500) % 2) == 1) s_ack = ($urandom_range(0, 19) == 0);
      else                      s_ack = ($urandom_range(0, 1) == 1);
      s_err = ($urandom_range(0, 39) == 0);
      #1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
